alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter: DW, 32, operand/result width; the only supported value is 32.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  1  request offered.
REQ-005 SHALL have port: req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-006 SHALL have port: req_op  input  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 NOR, 6-7 illegal.
REQ-007 SHALL have ports: req_a, req_b  input  DW  operands.
REQ-008 SHALL have ports: alu_src1, alu_src2  output  DW  registered operands driven to the 32-bit ALU.
REQ-009 SHALL have port: alu_ctrl  output  4  ALU control: bit3 A_invert, bit2 B_invert/carry-in, bits1:0 operation (00 AND, 01 OR, 10 add, 11 less).
REQ-010 SHALL have ports: alu_result (DW), alu_zero, alu_cout, alu_overflow (1 each)  input  combinational ALU outputs.
REQ-011 SHALL have port: rsp_valid  output  1  response available.
REQ-012 SHALL have port: rsp_ready  input  1  consumer accepts response.
REQ-013 SHALL have ports: rsp_result (DW), rsp_zero, rsp_cout, rsp_overflow, rsp_err (1 each)  output  captured response.
REQ-014 SHALL have port: ovf_cnt  output  8  overflow counter (present only with ALU_ISSUE_OVF_CNT_EN).

Function
REQ-015 SHALL map req_op to alu_ctrl: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-016 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-017 SHALL assert req_ready in IDLE, and in RESP only while rsp_ready is 1; it SHALL be 0 in EXEC.
REQ-018 IDLE + accept of a legal op SHALL register operands and alu_ctrl, then go to EXEC.
REQ-019 EXEC SHALL last exactly one cycle, capture alu_result/zero/cout/overflow into the rsp registers with rsp_err=0, then go to RESP.
REQ-020 Accept of an illegal op (6, 7) SHALL skip EXEC: go directly to RESP with rsp_err=1, rsp_result=0, and all flags 0.
REQ-021 RESP SHALL hold rsp_valid=1 and all rsp_* outputs stable until rsp_ready=1.
REQ-022 On RESP with rsp_ready=1 and no new accept, the FSM SHALL return to IDLE.
REQ-023 On RESP with rsp_ready=1 and a simultaneous accept, the FSM SHALL retire the response and load the new request (EXEC, or RESP if illegal) in the same edge.
REQ-024 Latency SHALL be 2 cycles from accept to rsp_valid for legal ops and 1 cycle for illegal ops; peak throughput SHALL be one legal op per 2 cycles.
REQ-025 alu_src1, alu_src2, and alu_ctrl SHALL change only on accept.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE; req_ready 1; rsp_valid 0; rsp_result 0; rsp flags 0; rsp_err 0; alu_src1/alu_src2 0; alu_ctrl 0000; ovf_cnt 0.
REQ-027 Reset mid-operation SHALL discard any in-flight request and pending response without emitting it.

Configuration
REQ-028 With ALU_ISSUE_OVF_CNT_EN defined, ovf_cnt SHALL increment by 1 on each EXEC capture where op is ADD or SUB and alu_overflow=1, saturating at 255.
REQ-029 Without ALU_ISSUE_OVF_CNT_EN, the ovf_cnt port and its counter SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-030 A shared package SHALL hold the req_op codes, the alu_ctrl encodings, and the FSM state enum.
REQ-031 The op-to-alu_ctrl decode SHALL be a sub-module named alu_op_decode (combinational, outputs ctrl and illegal).

Verification
REQ-032 Scenario 1: ADD a=5, b=7, rsp_ready=1 -> alu_ctrl=0010 one cycle after accept; rsp_valid two cycles after accept with rsp_result=12, zero=0, err=0.
REQ-033 Scenario 2: SUB a=0x7FFFFFFF-style overflow case a=0x80000000, b=1 -> rsp_overflow=1; ovf_cnt increments 0->1 (macro on).
REQ-034 Scenario 3: SLT a=-1, b=0 -> rsp_result=1; SUB a=3, b=3 -> rsp_result=0, zero=1.
REQ-035 Scenario 4: hold rsp_ready=0 for 5 cycles after a response -> rsp_* stable and req_ready=0 throughout; raise rsp_ready with req_valid=1 -> back-to-back accept on the same edge.
REQ-036 Scenario 5: req_op=7 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_result=0; alu_ctrl unchanged.
REQ-037 Scenario 6: assert rst_n=0 during EXEC -> rsp_valid=0 immediately, state IDLE, no response after release.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg -- shared definitions for the ALU issue block.
//   * req_op codes as seen on the request interface
//   * alu_ctrl encodings {A_invert, B_invert/carry-in, op[1:0]}
//   * issue FSM state enum
package alu_issue_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_NOR = 3'd5;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True for the ops whose overflow flag is meaningful (ADD, SUB).
    function automatic logic is_add_sub(input logic [3:0] ctrl);
        return (ctrl == CTRL_ADD) || (ctrl == CTRL_SUB);
    endfunction

endpackage

// File: rtl/alu_issue_op_decode.sv
// alu_op_decode -- combinational req_op -> alu_ctrl decode.
// Ports:
//   op      in  [2:0]  request opcode
//   ctrl    out [3:0]  ALU control word (0000 for illegal codes)
//   illegal out        opcode 6 or 7
module alu_op_decode
    import alu_issue_pkg::*;
(
    input  logic [2:0] op,
    output logic [3:0] ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = CTRL_AND;
        illegal = 1'b0;
        case (op)
            OP_AND:  ctrl = CTRL_AND;
            OP_OR:   ctrl = CTRL_OR;
            OP_ADD:  ctrl = CTRL_ADD;
            OP_SUB:  ctrl = CTRL_SUB;
            OP_SLT:  ctrl = CTRL_SLT;
            OP_NOR:  ctrl = CTRL_NOR;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue -- issues one request at a time to an external combinational
// 32-bit ALU and holds the captured result until the consumer takes it.
// Build option: define ALU_ISSUE_OVF_CNT_EN to add the saturating 8-bit
// ovf_cnt port counting ADD/SUB overflows.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready/req_op/req_a/req_b   request handshake + payload
//   alu_src1/alu_src2/alu_ctrl      registered ALU operands and control
//   alu_result/zero/cout/overflow   ALU outputs (combinational from above)
//   rsp_valid/rsp_ready/rsp_*       response handshake + captured result
//   ovf_cnt                         overflow counter (option only)
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    output logic [DW-1:0] alu_src1,
    output logic [DW-1:0] alu_src2,
    output logic [3:0]    alu_ctrl,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero,
    input  logic          alu_cout,
    input  logic          alu_overflow,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_result,
    output logic          rsp_zero,
    output logic          rsp_cout,
    output logic          rsp_overflow,
    output logic          rsp_err
`ifdef ALU_ISSUE_OVF_CNT_EN
    ,
    output logic [7:0]    ovf_cnt
`endif
);

    state_t     state, state_nxt;
    logic [3:0] dec_ctrl;
    logic       dec_illegal;
    logic       load_op;   // accept of a legal op: load operands/ctrl
    logic       load_err;  // accept of an illegal op: post error response
    logic       capture;   // EXEC: latch ALU outputs into response

    alu_op_decode u_dec (
        .op      (req_op),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        load_op   = 1'b0;
        load_err  = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_EXEC: begin
                capture   = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                // Ready for a new request only when the held response
                // retires on the same edge.
                req_ready = rsp_ready;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (req_valid && req_ready) begin
            if (dec_illegal) begin
                load_err  = 1'b1;
                state_nxt = ST_RESP;
            end else begin
                load_op   = 1'b1;
                state_nxt = ST_EXEC;
            end
        end
    end

    assign rsp_valid = (state == ST_RESP);

    // Illegal ops leave the ALU-side registers untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_src1 <= '0;
            alu_src2 <= '0;
            alu_ctrl <= CTRL_AND;
        end else if (load_op) begin
            alu_src1 <= req_a;
            alu_src2 <= req_b;
            alu_ctrl <= dec_ctrl;
        end
    end

    // capture and load_err are exclusive: req_ready is low in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else if (capture) begin
            rsp_result   <= alu_result;
            rsp_zero     <= alu_zero;
            rsp_cout     <= alu_cout;
            rsp_overflow <= alu_overflow;
            rsp_err      <= 1'b0;
        end else if (load_err) begin
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b1;
        end
    end

`ifdef ALU_ISSUE_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (capture && is_add_sub(alu_ctrl) && alu_overflow
                     && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue -- randomized + directed bench for alu_issue. A behavioural
// ALU drives the alu_* inputs; expected responses are queued on accept and
// checked by a monitor whenever rsp_valid is high.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero, alu_cout, alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_cout, rsp_overflow, rsp_err;
`ifdef ALU_ISSUE_OVF_CNT_EN
    logic [7:0]  ovf_cnt;
`endif

    always #5 clk = ~clk;

    alu_issue #(.DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
        .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_cout(rsp_cout),
        .rsp_overflow(rsp_overflow), .rsp_err(rsp_err)
`ifdef ALU_ISSUE_OVF_CNT_EN
        , .ovf_cnt(ovf_cnt)
`endif
    );

    // Behavioural 32-bit ALU: optional inversion, adder with carry-in,
    // logic ops, set-less-than from sign^overflow. Flags only for adder ops.
    logic [31:0] ea, eb, es;
    logic        ec, eo;
    always_comb begin
        ea = alu_ctrl[3] ? ~alu_src1 : alu_src1;
        eb = alu_ctrl[2] ? ~alu_src2 : alu_src2;
        {ec, es} = {1'b0, ea} + {1'b0, eb} + {32'd0, alu_ctrl[2]};
        eo = (ea[31] == eb[31]) && (es[31] != ea[31]);
        case (alu_ctrl[1:0])
            2'b00:   alu_result = ea & eb;
            2'b01:   alu_result = ea | eb;
            2'b10:   alu_result = es;
            default: alu_result = {31'd0, es[31] ^ eo};
        endcase
        alu_zero     = (alu_result == 32'd0);
        alu_cout     = alu_ctrl[1] & ec;
        alu_overflow = alu_ctrl[1] & eo;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] res;
        logic        z, c, v, e;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   rand_rdy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what each op means arithmetically.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] w;
        logic [31:0] d;
        e.op = op; e.res = '0; e.c = 1'b0; e.v = 1'b0; e.e = 1'b0;
        e.lat = 2; e.acc = 0;
        d = a - b;
        case (op)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: begin
                w = {1'b0, a} + {1'b0, b};
                e.res = w[31:0];
                e.c = w[32];
                e.v = (a[31] == b[31]) && (w[31] != a[31]);
            end
            3'd3, 3'd4: begin
                e.res = (op == 3'd3) ? d : (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                e.c = (a >= b);
                e.v = (a[31] != b[31]) && (d[31] != a[31]);
            end
            3'd5: e.res = ~(a | b);
            default: begin e.e = 1'b1; e.lat = 1; end
        endcase
        e.z = !e.e && (e.res == 32'd0);
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Drive a request until accepted; push expectation at the handshake.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int tries);
        bit done = 0;
        exp_t e;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; tries = 0;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                e = model(op, a, b);
                e.acc = cyc;
                q.push_back(e);
                done = 1;
            end else begin
                tries++;
                if (tries >= 100) begin
                    chk("accept_timeout", 64'(tries), 64'd0);
                    done = 1;
                end
            end
            @(posedge clk); #1;
            if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Monitor: compare held response every cycle it is visible (covers
    // stability), check latency on first appearance, retire on handshake.
    initial begin
        exp_t e;
        bit   pv = 0, pf = 0;
        int   exp_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 0; pf = 0; exp_cnt = 0;
            end else begin
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
                    end else begin
                        e = q[0];
                        chk("rsp", {28'd0, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err},
                                   {28'd0, e.res, e.z, e.c, e.v, e.e});
                        if (!pv || pf) begin
                            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                            if ((e.op == 3'd2 || e.op == 3'd3) && e.v && exp_cnt < 255) exp_cnt++;
                        end
                        if (rsp_ready) void'(q.pop_front());
                    end
                end
`ifdef ALU_ISSUE_OVF_CNT_EN
                chk("ovf_cnt", {56'd0, ovf_cnt}, 64'(exp_cnt));
`endif
                pv = rsp_valid;
                pf = rsp_valid && rsp_ready;
            end
        end
    end

    initial begin
        int          t;
        logic [3:0]  saved;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [31:0] edge_v [4];
        edge_v[0] = 32'h8000_0000; edge_v[1] = 32'h7FFF_FFFF;
        edge_v[2] = 32'hFFFF_FFFF; edge_v[3] = 32'h0000_0000;

        // Reset state
        #3;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp", {28'd0, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err}, 64'd0);
        chk("rst_src", {alu_src1, alu_src2}, 64'd0);
        chk("rst_ctrl", {60'd0, alu_ctrl}, 64'd0);
`ifdef ALU_ISSUE_OVF_CNT_EN
        chk("rst_ovf_cnt", {56'd0, ovf_cnt}, 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        idle(1);

        // Scenario 1: ADD 5+7
        issue(3'd2, 32'd5, 32'd7, t);
        chk("s1_ctrl", {60'd0, alu_ctrl}, 64'b0010);
        chk("s1_src", {alu_src1, alu_src2}, {32'd5, 32'd7});
        @(negedge clk);
        chk("s1_exec_no_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        chk("s1_valid", {63'd0, rsp_valid}, 64'd1);
        chk("s1_result", {32'd0, rsp_result}, 64'd12);
        @(posedge clk); #1;

        // Scenario 2: SUB overflow
        issue(3'd3, 32'h8000_0000, 32'd1, t);
        idle(3);

        // Scenario 3: SLT -1<0, SUB 3-3
        issue(3'd4, 32'hFFFF_FFFF, 32'd0, t);
        issue(3'd3, 32'd3, 32'd3, t);
        idle(3);

        // Scenario 4: hold response, then back-to-back accept
        rsp_ready = 1'b0;
        issue(3'd2, 32'hDEAD_0000, 32'h0000_BEEF, t);
        idle(1);
        repeat (5) begin
            @(negedge clk);
            chk("s4_hold_ready", {63'd0, req_ready}, 64'd0);
            chk("s4_hold_valid", {63'd0, rsp_valid}, 64'd1);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        issue(3'd3, 32'd10, 32'd20, t);
        chk("s4_b2b_tries", 64'(t), 64'd0);
        chk("s4_b2b_ctrl", {60'd0, alu_ctrl}, 64'b0110);
        idle(3);

        // Scenario 5: illegal op
        saved = alu_ctrl;
        issue(3'd7, 32'd1, 32'd2, t);
        chk("s5_ctrl_kept", {60'd0, alu_ctrl}, {60'd0, saved});
        chk("s5_err", {63'd0, rsp_err}, 64'd1);
        issue(3'd6, 32'd3, 32'd4, t);
        idle(3);

        // Scenario 6: reset during EXEC
        issue(3'd1, 32'hF0F0_0000, 32'h0000_0F0F, t);
        #1 rst_n = 1'b0;
        #1;
        chk("s6_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("s6_req_ready", {63'd0, req_ready}, 64'd1);
        chk("s6_ctrl", {60'd0, alu_ctrl}, 64'd0);
        q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        idle(5);
        chk("s6_no_rsp", {63'd0, rsp_valid}, 64'd0);

        // Random traffic with random consumer back-pressure
        rand_rdy = 1;
        repeat (300) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
                2: begin a = edge_v[$urandom_range(0, 3)]; b = edge_v[$urandom_range(0, 3)]; end
                default: begin a = $urandom; b = a; end
            endcase
            issue(op, a, b, t);
            idle($urandom_range(0, 2));
        end

        // Drain
        rand_rdy = 0;
        rsp_ready = 1'b1;
        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("final_idle", {62'd0, rsp_valid, req_ready}, 64'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

endmodule
